// File: rtl/line_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : line_delay_ctrl
// Function : Line-delay controller pairing each pixel with the one DEPTH earlier
// Revision : 1.0
// ============================================================================
module line_delay_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 10,
  parameter int FRAME_LEN  = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_delayed,
  output logic [DATA_WIDTH-1:0] out_cur,
  output logic                  frame_done
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DRN_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] c_frame_last = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] c_fill_last  = CNT_W'(DEPTH - 1);
  localparam logic [DRN_W-1:0] c_drain_last = DRN_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_in_cnt;
  logic [DRN_W-1:0]      r_drain_cnt;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_cur;
  logic                  r_frame_done;

  logic                  w_accept;
  logic                  w_rd_en;
  logic                  w_frame_end;
  logic                  w_drain_end;

  assign w_frame_end = (r_in_cnt == c_frame_last);
  assign w_drain_end = (r_state == DRAIN) && (r_drain_cnt == c_drain_last);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_rd_en     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (w_accept && (r_in_cnt == c_fill_last))
          w_state_nxt = w_frame_end ? DRAIN : STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        // Oldest entry is read in the same cycle it is overwritten.
        w_rd_en  = w_accept;
        if (w_accept && w_frame_end)
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_rd_en = 1'b1;
        if (w_drain_end)
          w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  assign ram_wr_en   = w_accept;
  assign ram_rd_en   = w_rd_en;
  assign ram_data_in = in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_in_cnt     <= '0;
      r_drain_cnt  <= '0;
      r_out_valid  <= 1'b0;
      r_out_cur    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_out_valid  <= w_rd_en;
      r_out_cur    <= (w_accept && w_rd_en) ? in_data : '0;
      r_frame_done <= w_drain_end;
      if (w_accept)
        r_in_cnt <= w_frame_end ? '0 : r_in_cnt + 1'b1;
      if (r_state == DRAIN)
        r_drain_cnt <= w_drain_end ? '0 : r_drain_cnt + 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_delayed = ram_data_out;
  assign out_cur     = r_out_cur;
  assign frame_done  = r_frame_done;

endmodule
`default_nettype wire
